// File: rtl/fir_coef_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fir_coef_loader
//  Description : Writer side of the FIR coefficient interface. Streams TAPS
//                signed coefficients into a shadow bank over valid/ready and
//                swaps the shadow into the active bank on a filter sample
//                boundary. The filter only ever sees a complete set.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_coef_loader #(
    parameter int TAPS   = 102,
    parameter int COEF_W = 32,
    parameter int CNT_W  = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic                     cin_valid,
    output logic                     cin_ready,
    input  logic [COEF_W-1:0]        cin_data,
    input  logic                     cin_last,
    input  logic                     swap_en,
    output logic [TAPS*COEF_W-1:0]   coef_flat,
    output logic                     bank_sel,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [1:0]               err_code
);

    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(TAPS - 1);
    localparam logic [1:0]       ERR_NONE   = 2'd0;
    localparam logic [1:0]       ERR_SHORT  = 2'd1;
    localparam logic [1:0]       ERR_LONG   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_SWAP = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                bank_sel_q;
    logic                cin_ready_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [1:0]          err_code_q;

    logic [COEF_W-1:0]   bank0_q [TAPS];
    logic [COEF_W-1:0]   bank1_q [TAPS];

    // A word is written only on a real handshake; a restart in the same
    // cycle drops the word so the new load starts cleanly at index 0.
    logic                w_wr;
    assign w_wr  = (state_q == ST_LOAD) && cin_valid && !load_start;
    assign cnt_d = cnt_q + 1'b1;

    // Load/swap control with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bank_sel_q  <= 1'b0;
            cin_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        state_q     <= ST_LOAD;
                        cnt_q       <= '0;
                        err_code_q  <= ERR_NONE;
                        cin_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (load_start) begin
                        cnt_q      <= '0;
                        err_code_q <= ERR_NONE;
                    end else if (cin_valid) begin
                        cnt_q <= cnt_d;
                        if (cin_last && (cnt_q == LAST_IDX)) begin
                            state_q     <= ST_WAIT_SWAP;
                            cin_ready_q <= 1'b0;
                        end else if (cin_last || (cnt_q == LAST_IDX)) begin
                            // Short set (last too early) or long set (no last on final index)
                            state_q     <= ST_IDLE;
                            cin_ready_q <= 1'b0;
                            busy_q      <= 1'b0;
                            err_q       <= 1'b1;
                            err_code_q  <= cin_last ? ERR_SHORT : ERR_LONG;
                        end
                    end
                end
                ST_WAIT_SWAP: begin
                    if (load_start) begin
                        state_q     <= ST_LOAD;
                        cnt_q       <= '0;
                        err_code_q  <= ERR_NONE;
                        cin_ready_q <= 1'b1;
                    end else if (swap_en) begin
                        state_q    <= ST_IDLE;
                        bank_sel_q <= ~bank_sel_q;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cin_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Shadow-bank write: only the bank not selected by bank_sel is touched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                bank0_q[i] <= '0;
                bank1_q[i] <= '0;
            end
        end else if (w_wr) begin
            if (bank_sel_q) begin
                bank0_q[cnt_q] <= cin_data;
            end else begin
                bank1_q[cnt_q] <= cin_data;
            end
        end
    end

    // Active bank onto the flat coefficient bus, registers-through-mux only.
    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_flat
            assign coef_flat[gi*COEF_W +: COEF_W] = bank_sel_q ? bank1_q[gi] : bank0_q[gi];
        end
    endgenerate

    assign cin_ready = cin_ready_q;
    assign bank_sel  = bank_sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_coef_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_coef_loader
//  Description : Self-checking bench for fir_coef_loader. Random coefficient
//                streams are compared against an array-level model of the
//                active set, bank index and error status.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_coef_loader;

    localparam int TAPS   = 102;
    localparam int COEF_W = 32;
    localparam int CNT_W  = 7;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   load_start = 1'b0;
    logic                   cin_valid = 1'b0;
    logic                   cin_ready;
    logic [COEF_W-1:0]      cin_data = '0;
    logic                   cin_last = 1'b0;
    logic                   swap_en = 1'b0;
    logic [TAPS*COEF_W-1:0] coef_flat;
    logic                   bank_sel;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [1:0]             err_code;

    fir_coef_loader #(
        .TAPS   (TAPS),
        .COEF_W (COEF_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .cin_valid  (cin_valid),
        .cin_ready  (cin_ready),
        .cin_data   (cin_data),
        .cin_last   (cin_last),
        .swap_en    (swap_en),
        .coef_flat  (coef_flat),
        .bank_sel   (bank_sel),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the set the filter should see and which bank holds it.
    logic [COEF_W-1:0] exp_act [TAPS];
    logic [COEF_W-1:0] stream  [TAPS];
    logic              exp_sel;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One comparison over the whole bus, reporting the first differing slot.
    task automatic check_coefs(input string tag);
        int bad;
        bad = -1;
        for (int i = 0; i < TAPS; i++)
            if (bad < 0 && coef_flat[i*COEF_W +: COEF_W] !== exp_act[i]) bad = i;
        if (bad < 0) bad = 0;
        check($sformatf("%s[%0d]", tag, bad),
              64'(coef_flat[bad*COEF_W +: COEF_W]), 64'(exp_act[bad]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input string tag);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check({tag, "_ready"}, 64'(cin_ready), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_errcode"}, 64'(err_code), 64'd0);
    endtask

    task automatic send_word(input logic [COEF_W-1:0] d, input logic last, input bit gate);
        if (gate) begin
            repeat ($urandom_range(0, 2)) begin
                cin_valid = 1'b0;
                tick();
            end
        end
        cin_valid = 1'b1;
        cin_data  = d;
        cin_last  = last;
        if (cin_ready !== 1'b1) begin
            check("ready_in_load", 64'(cin_ready), 64'd1);
        end
        tick();
        cin_valid = 1'b0;
        cin_last  = 1'b0;
        cin_data  = $urandom;
    endtask

    task automatic fill_random();
        for (int k = 0; k < TAPS; k++) stream[k] = $urandom;
    endtask

    task automatic load_set(input bit gate);
        for (int k = 0; k < TAPS; k++) send_word(stream[k], (k == TAPS - 1), gate);
    endtask

    task automatic model_swap();
        for (int k = 0; k < TAPS; k++) exp_act[k] = stream[k];
        exp_sel = ~exp_sel;
    endtask

    initial begin
        for (int k = 0; k < TAPS; k++) exp_act[k] = '0;
        exp_sel = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_bank_sel", 64'(bank_sel), 64'd0);
        check("rst_ready", 64'(cin_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_errcode", 64'(err_code), 64'd0);
        check_coefs("rst_coef");

        // Ramp set with swap_en held high: minimum-latency swap
        swap_en = 1'b1;
        for (int k = 0; k < TAPS; k++) stream[k] = COEF_W'(k + 1);
        start_load("t1");
        load_set(1'b0);
        check("t1_done_early", 64'(done), 64'd0);
        check("t1_sel_early", 64'(bank_sel), 64'd0);
        tick();
        model_swap();
        check("t1_done", 64'(done), 64'd1);
        check("t1_sel", 64'(bank_sel), 64'(exp_sel));
        check("t1_slot0", 64'(coef_flat[0 +: COEF_W]), 64'd1);
        check("t1_slot101", 64'(coef_flat[101*COEF_W +: COEF_W]), 64'd102);
        check_coefs("t1_coef");
        tick();
        check("t1_done_once", 64'(done), 64'd0);
        check("t1_idle_busy", 64'(busy), 64'd0);

        // Held swap: 50 cycles in WAIT_SWAP, then one swap_en pulse
        swap_en = 1'b0;
        fill_random();
        start_load("t2");
        load_set(1'b0);
        for (int c = 0; c < 50; c++) begin
            check("t2_wait_busy", 64'(busy), 64'd1);
            check("t2_wait_done", 64'(done), 64'd0);
            check_coefs("t2_wait_coef");
            tick();
        end
        swap_en = 1'b1;
        tick();
        swap_en = 1'b0;
        model_swap();
        check("t2_done", 64'(done), 64'd1);
        check("t2_sel", 64'(bank_sel), 64'(exp_sel));
        check_coefs("t2_coef");
        tick();
        check("t2_done_once", 64'(done), 64'd0);

        // Short set: last on word 50
        swap_en = 1'b1;
        start_load("t3");
        for (int k = 0; k < 50; k++) send_word($urandom, 1'b0, 1'b1);
        check("t3_no_err_yet", 64'(err), 64'd0);
        send_word($urandom, 1'b1, 1'b0);
        check("t3_err", 64'(err), 64'd1);
        check("t3_errcode", 64'(err_code), 64'd1);
        check("t3_done", 64'(done), 64'd0);
        tick();
        check("t3_err_pulse", 64'(err), 64'd0);
        check("t3_ready", 64'(cin_ready), 64'd0);
        check("t3_errcode_hold", 64'(err_code), 64'd1);
        check("t3_sel", 64'(bank_sel), 64'(exp_sel));
        check_coefs("t3_coef");

        // Long set: 102 words without last
        start_load("t4");
        for (int k = 0; k < TAPS; k++) begin
            send_word($urandom, 1'b0, 1'b1);
            if (k == TAPS - 2) check("t4_no_err_yet", 64'(err), 64'd0);
        end
        check("t4_err", 64'(err), 64'd1);
        check("t4_errcode", 64'(err_code), 64'd2);
        tick();
        tick();
        check("t4_done", 64'(done), 64'd0);
        check("t4_ready", 64'(cin_ready), 64'd0);
        check("t4_sel", 64'(bank_sel), 64'(exp_sel));
        check_coefs("t4_coef");

        // Restart after 30 words (with a word offered in the restart cycle)
        start_load("t5");
        for (int k = 0; k < 30; k++) send_word($urandom, 1'b0, 1'b1);
        load_start = 1'b1;
        cin_valid  = 1'b1;
        cin_data   = 32'hDEAD_BEEF;
        tick();
        load_start = 1'b0;
        cin_valid  = 1'b0;
        check("t5_restart_err", 64'(err), 64'd0);
        check("t5_restart_ready", 64'(cin_ready), 64'd1);
        fill_random();
        load_set(1'b1);
        tick();
        model_swap();
        check("t5_done", 64'(done), 64'd1);
        check("t5_sel", 64'(bank_sel), 64'(exp_sel));
        check("t5_errcode", 64'(err_code), 64'd0);
        check_coefs("t5_coef");

        // Asynchronous reset while waiting for the swap
        swap_en = 1'b0;
        fill_random();
        start_load("t6");
        load_set(1'b0);
        repeat (3) tick();
        check("t6_wait_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < TAPS; k++) exp_act[k] = '0;
        exp_sel = 1'b0;
        check_coefs("t6_rst_coef");
        check("t6_rst_sel", 64'(bank_sel), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_ready", 64'(cin_ready), 64'd0);
        check("t6_rst_done", 64'(done), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        swap_en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("t6_post_done", 64'(done), 64'd0);
            check("t6_post_sel", 64'(bank_sel), 64'd0);
            check("t6_post_busy", 64'(busy), 64'd0);
        end
        check_coefs("t6_post_coef");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case a task ever stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: got stalled expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/fir_coef_loader.md
Name: fir_coef_loader

Overview:
Writer side of the FIR coefficient interface. It accepts a stream of TAPS signed coefficients over a valid/ready handshake and stores them in a shadow bank. At a filter sample boundary it swaps the shadow bank into the active bank. The active bank drives the filter's coefficient bus, so a running filter never sees a partially loaded coefficient set.

Parameters:
TAPS, 102, number of coefficients per set
COEF_W, 32, coefficient width, signed two's complement
CNT_W, 7, width of the word counter; must satisfy 2**CNT_W >= TAPS

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
load_start  in  1  single-cycle pulse that begins or restarts a load
cin_valid  in  1  coefficient word valid
cin_ready  out  1  loader accepts a word this cycle
cin_data  in  COEF_W  coefficient; word k is coefficient index k
cin_last  in  1  marks the final word of the set
swap_en  in  1  filter sample-boundary strobe; a swap is allowed on this cycle
coef_flat  out  TAPS*COEF_W  active bank; coefficient i occupies bits [i*COEF_W +: COEF_W]
bank_sel  out  1  index of the active bank
busy  out  1  high in LOAD or WAIT_SWAP
done  out  1  one-cycle pulse when a swap completes
err  out  1  one-cycle pulse when a load fails
err_code  out  2  cause of the last error: 0 none, 1 short, 2 long; held until the next load_start

Behaviour:
- Reset: both banks cleared to 0, so coef_flat = 0. bank_sel=0, state IDLE, cin_ready=0, busy=0, done=0, err=0, err_code=0, counter=0.
- Two register banks of TAPS x COEF_W. bank_sel selects the active bank; the other bank is the shadow. Only the shadow is ever written.
- IDLE:
  - cin_ready=0; words presented here are ignored.
  - load_start -> LOAD; counter=0; err_code=0.
- LOAD:
  - cin_ready=1. A handshake is cin_valid && cin_ready.
  - On a handshake, shadow[counter] <= cin_data and counter increments.
  - Handshake with cin_last=1 and counter==TAPS-1: word written, go to WAIT_SWAP.
  - Handshake with cin_last=1 and counter<TAPS-1: err pulse, err_code=1, go to IDLE.
  - Handshake with cin_last=0 and counter==TAPS-1: word written, but err pulse, err_code=2, go to IDLE.
  - After either error the shadow content is undefined and is never swapped in.
- WAIT_SWAP:
  - cin_ready=0.
  - When swap_en=1: bank_sel toggles at that clock edge, so coef_flat shows the new set on the following cycle. done pulses in that same following cycle. Go to IDLE.
  - If swap_en is already high on the cycle WAIT_SWAP is entered, the swap happens on that cycle's edge. Minimum latency from the accepted last word to the new coef_flat is 2 cycles.
- load_start precedence:
  - load_start in LOAD restarts the load: counter=0, no error, and any handshake in that cycle is dropped.
  - load_start in WAIT_SWAP abandons the pending swap and goes to LOAD with counter=0; load_start wins over swap_en.
- swap_en in IDLE or LOAD has no effect.
- coef_flat is driven straight from registers through the bank mux: no combinational path from cin_* to coef_flat.
- Asynchronous reset mid-load or mid-wait returns to the reset state, including zeroed banks.
- done and err are never high in the same cycle.

Test Plan:
- Reset, then load 102 words with value k+1 for index k, last on k=101, swap_en held high. Required: bank_sel=1; coef_flat slot 0 = 1 and slot 101 = 102; a single done pulse 2 cycles after the last handshake.
- Load a full set, hold swap_en=0 for 50 cycles, then pulse it once. Required: coef_flat unchanged and busy=1 throughout the wait; swap and done happen only after the pulse.
- Set cin_last on word 50. Required: err pulse with err_code=1; bank_sel and coef_flat unchanged; cin_ready=0 afterwards.
- Send 102 words with cin_last never asserted. Required: err_code=2 on the 102nd handshake; no swap.
- Pulse load_start after 30 words, then send a clean 102-word set with cin_valid randomly gated. Required: the final set equals the second stream exactly.
- Assert rst during WAIT_SWAP. Required: coef_flat=0, bank_sel=0, state IDLE, no done pulse.
